// File: rtl/spu_fwd_pipe_pkg.sv
// Shared packet type, defaults and latency clamp for the SPU result-forwarding pipeline.
package spu_fwd_pipe_pkg;

  localparam int PKT_DATA_W       = 128;
  localparam int PKT_ADDR_W       = 7;
  localparam int PKT_LAT_W        = 3;
  localparam int DEF_NUM_PIPES    = 2;
  localparam int DEF_DEPTH        = 7;
  localparam int DEF_FLUSH_STAGES = 2;
  localparam int DEF_NUM_RD       = 6;

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [PKT_ADDR_W-1:0] addr;
    logic [PKT_LAT_W-1:0]  lat;
    logic [PKT_DATA_W-1:0] data;
  } fwd_pkt_t;

  localparam fwd_pkt_t PKT_NULL = fwd_pkt_t'({$bits(fwd_pkt_t){1'b0}});

  // Latency 0 behaves as 1; latencies past the pipe depth become ready at writeback.
  function automatic logic [PKT_LAT_W-1:0] clamp_lat(input logic [PKT_LAT_W-1:0] lat,
                                                     input int depth);
    logic [PKT_LAT_W-1:0] res;
    if (lat == {PKT_LAT_W{1'b0}}) begin
      res = {{(PKT_LAT_W-1){1'b0}}, 1'b1};
    end else if (int'(lat) > depth) begin
      res = PKT_LAT_W'(depth);
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/spu_fwd_pipe_fwd_match.sv
// Single bypass read port: youngest-stage-first, lowest-pipe-first match over the stage array.
module spu_fwd_pipe_fwd_match
  import spu_fwd_pipe_pkg::*;
#(
  parameter int NUM_PIPES = DEF_NUM_PIPES,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  fwd_pkt_t [NUM_PIPES-1:0][DEPTH-1:0] stages,
  input  logic [PKT_ADDR_W-1:0]               rd_addr,
  output logic                                hit,
  output logic                                stall,
  output logic [PKT_DATA_W-1:0]               data
);

  logic match_s;
  logic ready_s;

  // Sweep oldest to youngest so the final match written is the youngest stage, lowest pipe.
  always_comb begin
    hit     = 1'b0;
    stall   = 1'b0;
    data    = {PKT_DATA_W{1'b0}};
    match_s = 1'b0;
    ready_s = 1'b0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      for (int p = NUM_PIPES - 1; p >= 0; p--) begin
        match_s = stages[p][s].valid && stages[p][s].wr_en && (stages[p][s].addr == rd_addr);
        ready_s = (s + 1) >= int'(stages[p][s].lat);
        hit     = match_s ? ready_s : hit;
        stall   = match_s ? !ready_s : stall;
        data    = match_s ? (ready_s ? stages[p][s].data : {PKT_DATA_W{1'b0}}) : data;
      end
    end
  end

endmodule

// File: rtl/spu_fwd_pipe.sv
// NUM_PIPES x DEPTH result-forwarding shift pipeline with branch flush and multi-port bypass.
// Defining FWD_PIPE_PERF_EN adds saturating perf_hits / perf_stalls event counters.
module spu_fwd_pipe
  import spu_fwd_pipe_pkg::*;
#(
  parameter int NUM_PIPES    = DEF_NUM_PIPES,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DATA_W       = PKT_DATA_W,
  parameter int ADDR_W       = PKT_ADDR_W,
  parameter int LAT_W        = PKT_LAT_W,
  parameter int NUM_RD       = DEF_NUM_RD,
  parameter int FLUSH_STAGES = DEF_FLUSH_STAGES
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PIPES-1:0]                in_valid,
  input  logic [NUM_PIPES-1:0]                in_wr_en,
  input  logic [NUM_PIPES-1:0][ADDR_W-1:0]    in_addr,
  input  logic [NUM_PIPES-1:0][DATA_W-1:0]    in_data,
  input  logic [NUM_PIPES-1:0][LAT_W-1:0]     in_lat,
  input  logic                                flush,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]       rd_addr,
  output logic [NUM_RD-1:0]                   fwd_hit,
  output logic [NUM_RD-1:0][DATA_W-1:0]       fwd_data,
  output logic [NUM_RD-1:0]                   fwd_stall,
  output logic [NUM_PIPES-1:0]                wb_valid,
  output logic [NUM_PIPES-1:0][ADDR_W-1:0]    wb_addr,
  output logic [NUM_PIPES-1:0][DATA_W-1:0]    wb_data,
  output fwd_pkt_t [NUM_PIPES-1:0][DEPTH-1:0] st_tap
`ifdef FWD_PIPE_PERF_EN
  ,
  output logic [31:0]                         perf_hits,
  output logic [31:0]                         perf_stalls
`endif
);

  fwd_pkt_t [NUM_PIPES-1:0]            in_pkt_s;
  fwd_pkt_t [NUM_PIPES-1:0][DEPTH-1:0] st_r;
  fwd_pkt_t [NUM_PIPES-1:0][DEPTH-1:0] st_nxt_s;

  // Stage-1 packet; an idle slot enters as an all-zero bubble so the taps stay clean.
  always_comb begin
    in_pkt_s = {NUM_PIPES{PKT_NULL}};
    for (int p = 0; p < NUM_PIPES; p++) begin
      in_pkt_s[p].valid = in_valid[p];
      in_pkt_s[p].wr_en = in_valid[p] & in_wr_en[p];
      in_pkt_s[p].addr  = in_valid[p] ? in_addr[p] : {ADDR_W{1'b0}};
      in_pkt_s[p].lat   = in_valid[p] ? clamp_lat(in_lat[p], DEPTH) : {LAT_W{1'b0}};
      in_pkt_s[p].data  = in_valid[p] ? in_data[p] : {DATA_W{1'b0}};
    end
  end

  // Shift every clock; a flush turns the youngest FLUSH_STAGES destinations into bubbles.
  always_comb begin
    st_nxt_s = {(NUM_PIPES*DEPTH){PKT_NULL}};
    for (int p = 0; p < NUM_PIPES; p++) begin
      st_nxt_s[p][0] = flush ? PKT_NULL : in_pkt_s[p];
      for (int s = 1; s < DEPTH; s++) begin
        st_nxt_s[p][s] = (flush && (s < FLUSH_STAGES)) ? PKT_NULL : st_r[p][s-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int s = 0; s < DEPTH; s++) begin
          st_r[p][s] <= PKT_NULL;
        end
      end
    end else begin
      st_r <= st_nxt_s;
    end
  end

  assign st_tap = st_r;

  // Writeback port driven straight from the last stage register, zeroed when idle.
  always_comb begin
    wb_valid = {NUM_PIPES{1'b0}};
    wb_addr  = {(NUM_PIPES*ADDR_W){1'b0}};
    wb_data  = {(NUM_PIPES*DATA_W){1'b0}};
    for (int p = 0; p < NUM_PIPES; p++) begin
      wb_valid[p] = st_r[p][DEPTH-1].valid & st_r[p][DEPTH-1].wr_en;
      wb_addr[p]  = wb_valid[p] ? st_r[p][DEPTH-1].addr : {ADDR_W{1'b0}};
      wb_data[p]  = wb_valid[p] ? st_r[p][DEPTH-1].data : {DATA_W{1'b0}};
    end
  end

  genvar r;
  generate
    for (r = 0; r < NUM_RD; r++) begin : g_match
      spu_fwd_pipe_fwd_match #(
        .NUM_PIPES (NUM_PIPES),
        .DEPTH     (DEPTH)
      ) u_match (
        .stages  (st_r),
        .rd_addr (rd_addr[r]),
        .hit     (fwd_hit[r]),
        .stall   (fwd_stall[r]),
        .data    (fwd_data[r])
      );
    end
  endgenerate

`ifdef FWD_PIPE_PERF_EN
  logic [31:0] perf_hits_r;
  logic [31:0] perf_stalls_r;

  // Bypass event counters, one count per edge, saturating instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_hits_r   <= 32'd0;
      perf_stalls_r <= 32'd0;
    end else begin
      perf_hits_r   <= ((|fwd_hit) && (perf_hits_r != 32'hFFFF_FFFF)) ?
                       perf_hits_r + 32'd1 : perf_hits_r;
      perf_stalls_r <= ((|fwd_stall) && (perf_stalls_r != 32'hFFFF_FFFF)) ?
                       perf_stalls_r + 32'd1 : perf_stalls_r;
    end
  end

  assign perf_hits   = perf_hits_r;
  assign perf_stalls = perf_stalls_r;
`endif

endmodule

// File: tb/tb_spu_fwd_pipe.sv
// Self-checking bench for spu_fwd_pipe: directed scenarios plus random traffic against an issue-history model.
module tb_spu_fwd_pipe;
  import spu_fwd_pipe_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 7;
  localparam int NRD   = 6;
  localparam int FS    = 2;
  localparam int MAXE  = 2048;

  logic                            clock;
  logic                            reset;
  logic [NP-1:0]                   in_valid;
  logic [NP-1:0]                   in_wr_en;
  logic [NP-1:0][6:0]              in_addr;
  logic [NP-1:0][127:0]            in_data;
  logic [NP-1:0][2:0]              in_lat;
  logic                            flush;
  logic [NRD-1:0][6:0]             rd_addr;
  logic [NRD-1:0]                  fwd_hit;
  logic [NRD-1:0][127:0]           fwd_data;
  logic [NRD-1:0]                  fwd_stall;
  logic [NP-1:0]                   wb_valid;
  logic [NP-1:0][6:0]              wb_addr;
  logic [NP-1:0][127:0]            wb_data;
  fwd_pkt_t [NP-1:0][DEPTH-1:0]    st_tap;
`ifdef FWD_PIPE_PERF_EN
  logic [31:0]                     perf_hits;
  logic [31:0]                     perf_stalls;
`endif

  int n_checks   = 0;
  int n_errors   = 0;
  int n_edges    = 0;
  int reset_edge = 0;
  int model_hits   = 0;
  int model_stalls = 0;
  logic exp_any_hit;
  logic exp_any_stall;

  // Issue history: entry e holds what was loaded into stage 1 at clock edge e.
  logic         m_v    [MAXE][NP];
  logic         m_wr   [MAXE][NP];
  logic [6:0]   m_addr [MAXE][NP];
  int           m_lat  [MAXE][NP];
  logic [127:0] m_data [MAXE][NP];

  spu_fwd_pipe #(
    .NUM_PIPES    (NP),
    .DEPTH        (DEPTH),
    .NUM_RD       (NRD),
    .FLUSH_STAGES (FS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_wr_en  (in_wr_en),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_lat    (in_lat),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .fwd_stall (fwd_stall),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .st_tap    (st_tap)
`ifdef FWD_PIPE_PERF_EN
    ,
    .perf_hits   (perf_hits),
    .perf_stalls (perf_stalls)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // A packet loaded at edge e is alive if it was loaded after the last reset and not killed.
  function automatic bit live(input int e, input int p);
    if (e < 1 || e <= reset_edge) return 1'b0;
    return m_v[e][p];
  endfunction

  task automatic model_lookup(input logic [6:0] ra, output logic h, output logic st,
                              output logic [127:0] dt);
    bit found;
    int e;
    found = 1'b0;
    h = 1'b0;
    st = 1'b0;
    dt = 128'd0;
    for (int s = 1; s <= DEPTH; s++) begin
      e = n_edges - s + 1;
      for (int p = 0; p < NP; p++) begin
        if (!found && live(e, p) && m_wr[e][p] && m_addr[e][p] == ra) begin
          found = 1'b1;
          if (s >= m_lat[e][p]) begin
            h  = 1'b1;
            dt = m_data[e][p];
          end else begin
            st = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic         h;
    logic         st;
    logic [127:0] dt;
    logic         wv;
    int           e;
    logic [NP*DEPTH-1:0] exp_v;
    logic [NP*DEPTH-1:0] obs_v;
    exp_any_hit = 1'b0;
    exp_any_stall = 1'b0;
    for (int r = 0; r < NRD; r++) begin
      model_lookup(rd_addr[r], h, st, dt);
      check_eq($sformatf("fwd_hit[%0d]", r), fwd_hit[r], h);
      check_eq($sformatf("fwd_stall[%0d]", r), fwd_stall[r], st);
      check_eq($sformatf("fwd_data[%0d]", r), fwd_data[r], dt);
      exp_any_hit = exp_any_hit | h;
      exp_any_stall = exp_any_stall | st;
    end
    e = n_edges - DEPTH + 1;
    for (int p = 0; p < NP; p++) begin
      wv = live(e, p) && m_wr[e][p];
      check_eq($sformatf("wb_valid[%0d]", p), wb_valid[p], wv);
      check_eq($sformatf("wb_addr[%0d]", p), wb_addr[p], wv ? m_addr[e][p] : 7'd0);
      check_eq($sformatf("wb_data[%0d]", p), wb_data[p], wv ? m_data[e][p] : 128'd0);
    end
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < DEPTH; s++) begin
        exp_v[p*DEPTH+s] = live(n_edges - s, p);
        obs_v[p*DEPTH+s] = st_tap[p][s].valid;
      end
    end
    check_eq("stage_valid", obs_v, exp_v);
  endtask

  // Called just after a falling edge: drive, check the current state, clock once, update the model.
  task automatic step(input logic [NP-1:0] v, input logic [NP-1:0] wr,
                      input logic [NP-1:0][6:0] a, input logic [NP-1:0][2:0] l,
                      input logic [NP-1:0][127:0] d, input logic fl,
                      input logic [NRD-1:0][6:0] ra);
    in_valid = v;
    in_wr_en = wr;
    in_addr  = a;
    in_lat   = l;
    in_data  = d;
    flush    = fl;
    rd_addr  = ra;
    #1;
    check_outputs();
    @(posedge clock);
    if (exp_any_hit) model_hits++;
    if (exp_any_stall) model_stalls++;
    n_edges++;
    for (int p = 0; p < NP; p++) begin
      m_v[n_edges][p]    = v[p] && !fl;
      m_wr[n_edges][p]   = wr[p];
      m_addr[n_edges][p] = a[p];
      m_lat[n_edges][p]  = (l[p] == 3'd0) ? 1 : ((int'(l[p]) > DEPTH) ? DEPTH : int'(l[p]));
      m_data[n_edges][p] = d[p];
    end
    if (fl) begin
      for (int k = 1; k < FS; k++) begin
        if (n_edges - k >= 1) begin
          for (int p = 0; p < NP; p++) m_v[n_edges-k][p] = 1'b0;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input logic [NRD-1:0][6:0] ra);
    step(2'b00, 2'b00, 14'd0, 6'd0, 256'd0, 1'b0, ra);
  endtask

  initial begin
    logic [127:0]          da;
    logic [127:0]          db;
    logic [NRD-1:0][6:0]   ra_f;
    logic [NP-1:0]         rv;
    logic [NP-1:0]         rw;
    logic [NP-1:0][6:0]    r_a;
    logic [NP-1:0][2:0]    r_l;
    logic [NP-1:0][127:0]  r_d;
    logic [NRD-1:0][6:0]   r_ra;
    logic                  r_fl;

    reset    = 1'b1;
    in_valid = 2'b00;
    in_wr_en = 2'b00;
    in_addr  = 14'd0;
    in_data  = 256'd0;
    in_lat   = 6'd0;
    flush    = 1'b0;
    rd_addr  = 42'd0;
    repeat (2) @(negedge clock);
    #1;
    check_outputs();
    reset = 1'b0;

    // r5 with latency 2: stalls at stage 1, forwards from stage 2, writes back after 7 edges.
    da = rand128();
    step(2'b01, 2'b01, {7'd0, 7'd5}, {3'd0, 3'd2}, {128'd0, da}, 1'b0, {NRD{7'd5}});
    check_eq("t1_stall_s1", fwd_stall[0], 1'b1);
    check_eq("t1_hit_s1", fwd_hit[0], 1'b0);
    idle({NRD{7'd5}});
    check_eq("t1_hit_s2", fwd_hit[0], 1'b1);
    check_eq("t1_data_s2", fwd_data[0], da);
    repeat (5) idle({NRD{7'd5}});
    check_eq("t1_wb_valid", wb_valid[0], 1'b1);
    check_eq("t1_wb_addr", wb_addr[0], 7'd5);
    check_eq("t1_wb_data", wb_data[0], da);
    check_eq("t1_hit_s7", fwd_data[0], da);
    idle({NRD{7'd5}});

    // A younger not-ready r9 shadows an older ready r9.
    da = rand128();
    db = rand128();
    step(2'b01, 2'b01, {7'd0, 7'd9}, {3'd0, 3'd1}, {128'd0, da}, 1'b0, {NRD{7'd9}});
    step(2'b01, 2'b01, {7'd0, 7'd9}, {3'd0, 3'd4}, {128'd0, db}, 1'b0, {NRD{7'd9}});
    check_eq("t2_stall", fwd_stall[0], 1'b1);
    check_eq("t2_hit", fwd_hit[0], 1'b0);
    check_eq("t2_data", fwd_data[0], 128'd0);

    // Same-stage tie on r3: pipe 0 wins.
    step(2'b11, 2'b11, {7'd3, 7'd3}, {3'd1, 3'd1}, {db, da}, 1'b0, {NRD{7'd3}});
    check_eq("t3_hit", fwd_hit[0], 1'b1);
    check_eq("t3_data", fwd_data[0], da);

    // Flush with r10/r11/r12 in flight: r12 and the flush-cycle r13 vanish.
    ra_f = {7'd11, 7'd10, 7'd13, 7'd12, 7'd11, 7'd10};
    step(2'b01, 2'b01, {7'd0, 7'd10}, {3'd0, 3'd1}, {128'd0, rand128()}, 1'b0, ra_f);
    step(2'b01, 2'b01, {7'd0, 7'd11}, {3'd0, 3'd1}, {128'd0, rand128()}, 1'b0, ra_f);
    step(2'b01, 2'b01, {7'd0, 7'd12}, {3'd0, 3'd1}, {128'd0, rand128()}, 1'b0, ra_f);
    step(2'b01, 2'b01, {7'd0, 7'd13}, {3'd0, 3'd1}, {128'd0, rand128()}, 1'b1, ra_f);
    check_eq("fl_hit_r10", fwd_hit[0], 1'b1);
    check_eq("fl_hit_r11", fwd_hit[1], 1'b1);
    check_eq("fl_hit_r12", fwd_hit[2], 1'b0);
    check_eq("fl_stall_r12", fwd_stall[2], 1'b0);
    check_eq("fl_hit_r13", fwd_hit[3], 1'b0);
    repeat (8) idle(ra_f);

    // Asynchronous reset between edges while a packet sits at writeback.
    da = rand128();
    step(2'b01, 2'b01, {7'd0, 7'd5}, {3'd0, 3'd1}, {128'd0, da}, 1'b0, {NRD{7'd5}});
    repeat (6) idle({NRD{7'd5}});
    check_eq("pre_rst_wb", wb_valid, 2'b01);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_wb_valid", wb_valid, 2'b00);
    check_eq("rst_fwd_hit", fwd_hit, 6'd0);
    check_eq("rst_fwd_stall", fwd_stall, 6'd0);
    reset_edge = n_edges;
    @(negedge clock);
    reset = 1'b0;
    repeat (8) idle({NRD{7'd5}});

    // Random traffic over a small register window to force frequent matches.
    for (int i = 0; i < 600; i++) begin
      rv = 2'($urandom_range(0, 3));
      rw = 2'($urandom_range(0, 3));
      for (int p = 0; p < NP; p++) begin
        r_a[p] = 7'($urandom_range(0, 7));
        r_l[p] = 3'($urandom_range(0, 7));
        r_d[p] = rand128();
      end
      for (int r = 0; r < NRD; r++) r_ra[r] = 7'($urandom_range(0, 7));
      r_fl = ($urandom_range(0, 9) == 0);
      step(rv, rw, r_a, r_l, r_d, r_fl, r_ra);
    end

`ifdef FWD_PIPE_PERF_EN
    check_eq("perf_hits", perf_hits, model_hits);
    check_eq("perf_stalls", perf_stalls, model_stalls);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
